// File: rtl/uart_tx_async.sv
// uart_tx_async: UART transmitter paced by a 16x baud enable, with a
// one-byte holding register in front of the shift register.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   reset_n     synchronous active-low reset
//   baud_clock  one-clk enable at 16x the bit rate
//   bit8        1 = 8 data bits, 0 = 7 data bits
//   parity_en   1 = append a parity bit
//   odd_n_even  1 = odd parity, 0 = even parity
//   tx_data     byte to send
//   tx_write    one-clk load strobe for tx_data
//   tx          serial line, idles high
//   tx_ready    holding register empty
//   tx_busy     frame in progress
//   tx_done     one-clk pulse at the end of the last stop bit
module uart_tx_async #(
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_clock,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic [7:0] tx_data,
    input  logic       tx_write,
    output logic       tx,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [3:0] tick_cnt;
    logic       xmit_pulse;

    logic [7:0] hold;
    logic       hold_full;

    logic [2:0] state;
    logic [2:0] state_nx;
    logic [7:0] shift;
    logic [7:0] shift_nx;
    logic [2:0] bit_cnt;
    logic [2:0] bit_cnt_nx;
    logic       stop_cnt;
    logic       stop_cnt_nx;
    logic       par_acc;
    logic       par_acc_nx;
    logic       cfg_bit8;
    logic       cfg_bit8_nx;
    logic       cfg_par;
    logic       cfg_par_nx;
    logic       cfg_odd;
    logic       cfg_odd_nx;
    logic       tx_nx;
    logic       done_nx;

    logic       last_data;
    logic       last_stop;
    logic       frame_end;
    logic       start_xfer;

    // Bit boundaries come from a free-running prescaler; frames are not
    // re-phased to the write, so start latency is up to one bit period.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_cnt <= 4'd0;
        end else if (baud_clock) begin
            tick_cnt <= tick_cnt + 4'd1;
        end
    end

    assign xmit_pulse = baud_clock && (tick_cnt == 4'd15);

    assign hold_full = !tx_ready;
    assign tx_busy   = (state != IDLE);

    // bit_cnt holds the index of the data bit currently on the line.
    assign last_data = (bit_cnt == (cfg_bit8 ? 3'd7 : 3'd6));
    assign last_stop = (STOP_BITS == 1) || stop_cnt;
    assign frame_end = xmit_pulse && (state == STOP) && last_stop;

    // A new frame starts either from idle or directly off the end of the
    // previous stop bit, so back-to-back frames have no idle gap.
    assign start_xfer = xmit_pulse && hold_full &&
                        ((state == IDLE) || frame_end);

    // Holding register. A write on the transfer edge sees tx_ready=0 and
    // is dropped, so the transfer branch never competes with a load.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold     <= 8'h00;
            tx_ready <= 1'b1;
        end else if (start_xfer) begin
            tx_ready <= 1'b1;
        end else if (tx_write && tx_ready) begin
            hold     <= tx_data;
            tx_ready <= 1'b0;
        end
    end

    always_comb begin
        state_nx    = state;
        shift_nx    = shift;
        bit_cnt_nx  = bit_cnt;
        stop_cnt_nx = stop_cnt;
        par_acc_nx  = par_acc;
        cfg_bit8_nx = cfg_bit8;
        cfg_par_nx  = cfg_par;
        cfg_odd_nx  = cfg_odd;
        tx_nx       = tx;
        done_nx     = 1'b0;

        if (xmit_pulse) begin
            case (state)
                START: begin
                    tx_nx      = shift[0];
                    par_acc_nx = shift[0];
                    shift_nx   = {1'b0, shift[7:1]};
                    bit_cnt_nx = 3'd0;
                    state_nx   = DATA;
                end
                DATA: begin
                    if (last_data) begin
                        if (cfg_par) begin
                            // par_acc already covers every bit sent.
                            tx_nx    = par_acc ^ cfg_odd;
                            state_nx = PARITY;
                        end else begin
                            tx_nx       = 1'b1;
                            stop_cnt_nx = 1'b0;
                            state_nx    = STOP;
                        end
                    end else begin
                        tx_nx      = shift[0];
                        par_acc_nx = par_acc ^ shift[0];
                        shift_nx   = {1'b0, shift[7:1]};
                        bit_cnt_nx = bit_cnt + 3'd1;
                    end
                end
                PARITY: begin
                    tx_nx       = 1'b1;
                    stop_cnt_nx = 1'b0;
                    state_nx    = STOP;
                end
                STOP: begin
                    if (last_stop) begin
                        done_nx  = 1'b1;
                        tx_nx    = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        stop_cnt_nx = 1'b1;
                    end
                end
                default: begin
                    tx_nx    = 1'b1;
                    state_nx = IDLE;
                end
            endcase
        end

        // Transfer overrides the STOP->IDLE move but keeps done_nx.
        // Frame format is latched here so later input changes are ignored.
        if (start_xfer) begin
            shift_nx    = hold;
            cfg_bit8_nx = bit8;
            cfg_par_nx  = parity_en;
            cfg_odd_nx  = odd_n_even;
            bit_cnt_nx  = 3'd0;
            stop_cnt_nx = 1'b0;
            par_acc_nx  = 1'b0;
            tx_nx       = 1'b0;
            state_nx    = START;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            shift    <= 8'h00;
            bit_cnt  <= 3'd0;
            stop_cnt <= 1'b0;
            par_acc  <= 1'b0;
            cfg_bit8 <= 1'b0;
            cfg_par  <= 1'b0;
            cfg_odd  <= 1'b0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_nx;
            shift    <= shift_nx;
            bit_cnt  <= bit_cnt_nx;
            stop_cnt <= stop_cnt_nx;
            par_acc  <= par_acc_nx;
            cfg_bit8 <= cfg_bit8_nx;
            cfg_par  <= cfg_par_nx;
            cfg_odd  <= cfg_odd_nx;
            tx       <= tx_nx;
            tx_done  <= done_nx;
        end
    end

endmodule
